// File: rtl/dmux_pkg.sv
// Shared constants for the registered 1-to-2 demultiplexer.
// Optional statistics counters are enabled by defining DMUX_STATS_EN.
package dmux_pkg;

    // Select encoding: 0 routes to o0, 1 routes to o1.
    localparam logic SEL_O0 = 1'b0;
    localparam logic SEL_O1 = 1'b1;

    // Default data width and statistics counter width.
    localparam int DMUX_WIDTH_DEF = 1;
    localparam int DMUX_CNT_W_DEF = 16;

endpackage : dmux_pkg

// File: rtl/dmux_1to2_if.sv
// Bus bundle between the producer, the demultiplexer and its two consumers.
// The cnt0/cnt1 signals exist only when DMUX_STATS_EN is defined.
interface dmux_1to2_if
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH_DEF
`ifdef DMUX_STATS_EN
    ,
    parameter int CNT_W = DMUX_CNT_W_DEF
`endif
) ();

    logic             in_valid;
    logic [WIDTH-1:0] entrada;
    logic             sel;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic             o0_valid;
    logic             o1_valid;
`ifdef DMUX_STATS_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

`ifdef DMUX_STATS_EN
    // Producer/observer side: drives the input word, watches both channels.
    modport master (
        output in_valid, entrada, sel,
        input  o0, o1, o0_valid, o1_valid, cnt0, cnt1
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, entrada, sel,
        output o0, o1, o0_valid, o1_valid, cnt0, cnt1
    );
`else
    // Producer/observer side: drives the input word, watches both channels.
    modport master (
        output in_valid, entrada, sel,
        input  o0, o1, o0_valid, o1_valid
    );

    // Demultiplexer side.
    modport slave (
        input  in_valid, entrada, sel,
        output o0, o1, o0_valid, o1_valid
    );
`endif

endinterface : dmux_1to2_if

// File: rtl/dmux_sat_cnt.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones,
// and clears only on reset.
module dmux_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Increment on each inc pulse until the counter reaches its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule : dmux_sat_cnt

// File: rtl/dmux_1to2.sv
// Registered 1-to-2 demultiplexer with per-channel valid strobes.
// The unselected channel (and both channels when idle) is driven to zero,
// so no stale word is ever presented. Define DMUX_STATS_EN to add
// per-channel saturating transfer counters.
module dmux_1to2
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH_DEF
`ifdef DMUX_STATS_EN
    ,
    parameter int CNT_W = DMUX_CNT_W_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    dmux_1to2_if.slave bus
);

    // Channel-select decode: any select value other than SEL_O1 routes to o0.
    logic [1:0] w_ch_sel;

    logic [WIDTH-1:0] r_o0;
    logic [WIDTH-1:0] r_o1;
    logic             r_o0_valid;
    logic             r_o1_valid;

    // Decode the valid/select pair into one-hot channel enables.
    always_comb begin
        w_ch_sel    = 2'b00;
        w_ch_sel[1] = bus.in_valid && (bus.sel == SEL_O1);
        w_ch_sel[0] = bus.in_valid && !(bus.sel == SEL_O1);
    end

    // Output registers: the selected channel captures the word, the other clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o0       <= '0;
            r_o1       <= '0;
            r_o0_valid <= 1'b0;
            r_o1_valid <= 1'b0;
        end else begin
            r_o0       <= w_ch_sel[0] ? bus.entrada : '0;
            r_o1       <= w_ch_sel[1] ? bus.entrada : '0;
            r_o0_valid <= w_ch_sel[0];
            r_o1_valid <= w_ch_sel[1];
        end
    end

    assign bus.o0       = r_o0;
    assign bus.o1       = r_o1;
    assign bus.o0_valid = r_o0_valid;
    assign bus.o1_valid = r_o1_valid;

`ifdef DMUX_STATS_EN
    logic [CNT_W-1:0] w_cnt [2];

    // One saturating transfer counter per channel, stepped by that channel's enable.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        dmux_sat_cnt #(
            .W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (w_ch_sel[gi]),
            .count (w_cnt[gi])
        );
    end

    assign bus.cnt0 = w_cnt[0];
    assign bus.cnt1 = w_cnt[1];
`endif

endmodule : dmux_1to2

// File: tb/tb_dmux_1to2.sv
// Self-checking bench for dmux_1to2: a WIDTH=1 and a WIDTH=8 instance share
// clock, reset, valid and select; each gets its own data word.
// Expected outputs come from a behavioural model of the routing rules.
module tb_dmux_1to2;
    import dmux_pkg::*;

    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef DMUX_STATS_EN
    dmux_1to2_if #(.WIDTH(1), .CNT_W(CW)) b1 ();
    dmux_1to2_if #(.WIDTH(8), .CNT_W(CW)) b8 ();
    dmux_1to2 #(.WIDTH(1), .CNT_W(CW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    dmux_1to2 #(.WIDTH(8), .CNT_W(CW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
`else
    dmux_1to2_if #(.WIDTH(1)) b1 ();
    dmux_1to2_if #(.WIDTH(8)) b8 ();
    dmux_1to2 #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    dmux_1to2 #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: expected outputs after the most recent edge.
    logic       e1_o0, e1_o1, e_v0, e_v1;
    logic [7:0] e8_o0, e8_o1;
    int         e_cnt [2];

    // Unknown select with a valid input is unsupported stimulus.
    always @(posedge clk) begin
        if (rst_n && (b1.in_valid === 1'b1) && $isunknown(b1.sel)) begin
            n_err++;
            $display("FAIL sel_unknown: sel=%b while in_valid=1, required 0 or 1", b1.sel);
        end
    end

    task automatic model_clear();
        e1_o0 = 1'b0; e1_o1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
        e8_o0 = 8'h00; e8_o1 = 8'h00;
        e_cnt[0] = 0; e_cnt[1] = 0;
    endtask

    // Drive one input vector, let one edge sample it, then update the model.
    task automatic drive_cycle(input logic v, input logic s, input logic d1, input logic [7:0] d8);
        int ch;
        @(negedge clk);
        b1.in_valid = v; b1.sel = s; b1.entrada = d1;
        b8.in_valid = v; b8.sel = s; b8.entrada = d8;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            model_clear();
        end else begin
            ch    = (s == SEL_O1) ? 1 : 0;
            e_v0  = v && (ch == 0);
            e_v1  = v && (ch == 1);
            e1_o0 = e_v0 ? d1 : 1'b0;
            e1_o1 = e_v1 ? d1 : 1'b0;
            e8_o0 = e_v0 ? d8 : 8'h00;
            e8_o1 = e_v1 ? d8 : 8'h00;
            if (v) e_cnt[ch] = (e_cnt[ch] + 1 > 2**CW - 1) ? 2**CW - 1 : e_cnt[ch] + 1;
        end
        $display("cyc %0d rst_n=%b v=%b sel=%b d1=%b d8=%h -> o0=%h/%b o1=%h/%b", cyc, rst_n,
                 v, s, d1, d8, b8.o0, b8.o0_valid, b8.o1, b8.o1_valid);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 8'hFF);
            n_cmp++;
            if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid, b8.o0, b8.o1} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_hold: got w1=%b o0=%h o1=%h, required all 0",
                         {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid}, b8.o0, b8.o1);
            end
`ifdef DMUX_STATS_EN
            n_cmp++;
            if ({b1.cnt0, b1.cnt1} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_cnt: got cnt0=%0d cnt1=%0d, required 0 0", b1.cnt0, b1.cnt1);
            end
`endif
        end
        // Release between edges; the very next edge must sample normally.
        rst_n = 1'b1;
        drive_cycle(1'b1, 1'b1, 1'b1, 8'h5A);
        n_cmp++;
        if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid} !== {e1_o0, e1_o1, e_v0, e_v1}) begin
            n_err++;
            $display("FAIL reset_release: got %b, required %b",
                     {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid}, {e1_o0, e1_o1, e_v0, e_v1});
        end
    endtask

    task automatic test_routing();
        logic [1:0] vec [4];
        logic [1:0] tmp;
        vec[0] = 2'b11; vec[1] = 2'b10; vec[2] = 2'b01; vec[3] = 2'b00; // {entrada, sel}
        for (int i = 0; i < 4; i++) begin
            tmp = vec[i];
            drive_cycle(1'b1, tmp[0], tmp[1], {8{tmp[1]}});
            n_cmp++;
            if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid} !== {e1_o0, e1_o1, e_v0, e_v1}) begin
                n_err++;
                $display("FAIL routing[%0d] e=%b s=%b: got o0,o1,v0,v1=%b, required %b", i, tmp[1],
                         tmp[0], {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid},
                         {e1_o0, e1_o1, e_v0, e_v1});
            end
        end
    endtask

    task automatic test_idle();
        drive_cycle(1'b1, SEL_O0, 1'b1, 8'hA5);
        drive_cycle(1'b0, SEL_O0, 1'b1, 8'hFF);
        n_cmp++;
        if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid, b8.o0, b8.o1} !== 20'h0) begin
            n_err++;
            $display("FAIL idle: got w1=%b o0=%h o1=%h, required all 0",
                     {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid}, b8.o0, b8.o1);
        end
    endtask

    task automatic test_width();
        drive_cycle(1'b1, SEL_O1, 1'b1, 8'hA5);
        n_cmp++;
        if ({b8.o0, b8.o1, b8.o1_valid} !== {e8_o0, e8_o1, e_v1} || b8.o1 !== 8'hA5) begin
            n_err++;
            $display("FAIL width_sel1: got o0=%h o1=%h, required o0=%h o1=%h",
                     b8.o0, b8.o1, e8_o0, e8_o1);
        end
        drive_cycle(1'b1, SEL_O0, 1'b1, 8'hA5);
        n_cmp++;
        if ({b8.o0, b8.o1, b8.o0_valid} !== {e8_o0, e8_o1, e_v0} || b8.o0 !== 8'hA5) begin
            n_err++;
            $display("FAIL width_sel0: got o0=%h o1=%h, required o0=%h o1=%h",
                     b8.o0, b8.o1, e8_o0, e8_o1);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, SEL_O0, 1'b1, 8'h3C);
        n_cmp++;
        if (b8.o0_valid !== e_v0 || b8.o0 !== e8_o0) begin
            n_err++;
            $display("FAIL async_pre: got o0=%h v0=%b, required o0=%h v0=%b",
                     b8.o0, b8.o0_valid, e8_o0, e_v0);
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_cmp++;
        if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid, b8.o0, b8.o1, b8.o0_valid} !== 21'h0) begin
            n_err++;
            $display("FAIL async_reset: got w1=%b o0=%h o1=%h v0=%b, required all 0",
                     {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid}, b8.o0, b8.o1, b8.o0_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic       v, s, d1;
        logic [7:0] d8;
        for (int i = 0; i < 200; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            s  = 1'($urandom_range(0, 1));
            d1 = 1'($urandom_range(0, 1));
            d8 = 8'($urandom_range(0, 255));
            drive_cycle(v, s, d1, d8);
            n_cmp++;
            if ({b1.o0, b1.o1, b1.o0_valid, b1.o1_valid, b8.o0, b8.o1} !==
                {e1_o0, e1_o1, e_v0, e_v1, e8_o0, e8_o1}) begin
                n_err++;
                $display("FAIL random[%0d]: got w1=%b o0=%h o1=%h, required w1=%b o0=%h o1=%h", i,
                         {b1.o0, b1.o1, b1.o0_valid, b1.o1_valid}, b8.o0, b8.o1,
                         {e1_o0, e1_o1, e_v0, e_v1}, e8_o0, e8_o1);
            end
            n_cmp++;
            if ((b8.o0_valid & b8.o1_valid) !== 1'b0) begin
                n_err++;
                $display("FAIL exclusive[%0d]: got v0=%b v1=%b, required not both 1", i,
                         b8.o0_valid, b8.o1_valid);
            end
`ifdef DMUX_STATS_EN
            n_cmp++;
            if (b8.cnt0 !== CW'(e_cnt[0]) || b8.cnt1 !== CW'(e_cnt[1])) begin
                n_err++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d, required %0d/%0d", i,
                         b8.cnt0, b8.cnt1, e_cnt[0], e_cnt[1]);
            end
`endif
        end
    endtask

    task automatic test_stats();
        // Counters clear only on reset, so start from a fresh reset.
        rst_n = 1'b0;
        drive_cycle(1'b0, SEL_O0, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, SEL_O0, 1'b1, 8'(i));
`ifdef DMUX_STATS_EN
        n_cmp++;
        if (b1.cnt0 !== CW'(e_cnt[0]) || b1.cnt1 !== CW'(e_cnt[1])) begin
            n_err++;
            $display("FAIL stats_sat: got cnt0=%0d cnt1=%0d, required %0d %0d",
                     b1.cnt0, b1.cnt1, e_cnt[0], e_cnt[1]);
        end
`endif
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, SEL_O1, 1'b0, 8'hC3);
        n_cmp++;
        if ({b8.o0, b8.o1, b8.o1_valid} !== {e8_o0, e8_o1, e_v1}) begin
            n_err++;
            $display("FAIL stats_data: got o0=%h o1=%h, required o0=%h o1=%h",
                     b8.o0, b8.o1, e8_o0, e8_o1);
        end
`ifdef DMUX_STATS_EN
        n_cmp++;
        if (b8.cnt0 !== CW'(e_cnt[0]) || b8.cnt1 !== CW'(e_cnt[1])) begin
            n_err++;
            $display("FAIL stats_ch1: got cnt0=%0d cnt1=%0d, required %0d %0d",
                     b8.cnt0, b8.cnt1, e_cnt[0], e_cnt[1]);
        end
`endif
    endtask

    initial begin
        model_clear();
        b1.in_valid = 1'b0; b1.sel = 1'b0; b1.entrada = 1'b0;
        b8.in_valid = 1'b0; b8.sel = 1'b0; b8.entrada = 8'h00;
        test_reset();
        test_routing();
        test_idle();
        test_width();
        test_async_reset();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dmux_1to2

// File: doc/dmux_1to2.md
# dmux_1to2

Registered 1-to-2 demultiplexer. Each cycle it routes a WIDTH-bit input word to exactly one of two output channels, chosen by a 1-bit select, and drives the unselected channel to zero. It sits between a single producer and two consumers and presents registered, glitch-free outputs with per-channel valid strobes. Optional per-channel saturating transfer counters support debug and bring-up.

## Interface
- WIDTH, default 1: data width of `entrada`, `o0`, `o1`.
- CNT_W, default 16: width of the statistics counters; only meaningful with DMUX_STATS_EN.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  `entrada`/`sel` are valid this cycle.
- entrada  input  WIDTH  data word to route.
- sel  input  1  routing select: 0 selects `o0`, 1 selects `o1`.
- o0  output  WIDTH  channel-0 data.
- o1  output  WIDTH  channel-1 data.
- o0_valid  output  1  channel-0 strobe.
- o1_valid  output  1  channel-1 strobe.
- cnt0  output  CNT_W  channel-0 transfer count (DMUX_STATS_EN only).
- cnt1  output  CNT_W  channel-1 transfer count (DMUX_STATS_EN only).

One clock. Reset is asynchronous and active-low.

## Operation
- in_valid=1, sel=0: `o0`←`entrada`, o0_valid←1, `o1`←0, o1_valid←0.
- in_valid=1, sel=1: `o1`←`entrada`, o1_valid←1, `o0`←0, o0_valid←0.
- in_valid=0: `o0`, `o1`, o0_valid and o1_valid all ←0. Outputs never hold a stale word.
- A valid input is routed even when `entrada`=0. The valid strobe is asserted and the data is 0.
- o0_valid and o1_valid are never high in the same cycle.
- Unknown `sel` while in_valid=1 is not supported. The bench must flag it. The RTL treats any value other than 1 as 0.
- No backpressure: every valid input produces exactly one output strobe.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. Full throughput, one word per cycle.
- Reset value of every output is 0, including the counters. Outputs are forced low immediately on rst_n falling, independent of clk.
- Reset released mid-stream: the first edge with rst_n=1 samples the inputs normally.
- Counters: cntX increments by 1 on each edge where channel X is selected with in_valid=1.
  - Counters saturate at 2^CNT_W−1.
  - Counters clear only on reset.

## Configuration
- Macro DMUX_STATS_EN.
- Defined: `cnt0`/`cnt1` ports and counter logic are present.
- Undefined: those ports and that logic are absent; the data path is unchanged.

## Structure
- Package dmux_pkg holds:
  - SEL_O0=1'b0 and SEL_O1=1'b1.
  - DMUX_WIDTH_DEF=1 and DMUX_CNT_W_DEF=16.
- Sub-module dmux_sat_cnt is a saturating counter parameterized by width, with inputs clk, rst_n and inc and output count. It is instantiated twice under DMUX_STATS_EN.
- The top level holds the select decode and the output registers.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, entrada=1, sel=1 → o0=o1=0 and both valids=0; deassert → next edge o1=1, o1_valid=1.
- Routing, WIDTH=1, in_valid=1, one vector per cycle, each checked one cycle later:
  - entrada=1, sel=1 → o0=0, o1=1.
  - entrada=1, sel=0 → o0=1, o1=0.
  - entrada=0, sel=1 → o0=0, o1=0, o1_valid=1.
  - entrada=0, sel=0 → o0=0, o1=0, o0_valid=1.
- Idle: in_valid=0 with entrada=1, sel=0 → o0=o1=0 and both valids=0; previous data is not held.
- Width: WIDTH=8, entrada=8'hA5, sel=1 → o1=8'hA5, o0=8'h00. Then sel=0 → o0=8'hA5, o1=8'h00.
- Async reset: assert rst_n low between clock edges while o0_valid=1 → all outputs 0 before the next edge.
- Stats (DMUX_STATS_EN, CNT_W=4):
  - 20 valid cycles with sel=0 → cnt0=15 (saturated), cnt1=0.
  - Then 3 cycles with sel=1 → cnt1=3.
